// File: rtl/fir4_avg_fifo_if.sv
// fir4_avg_fifo_if: consumer-side valid/ready stream of averaged samples.
//   m_data  : head-of-FIFO average (0 when m_valid=0)
//   m_valid : FIFO non-empty
//   m_ready : consumer accepts the head when m_valid & m_ready
// master = producer (fir4_avg_fifo), slave = consumer.
interface fir4_avg_fifo_if #(
    parameter int W = 16
) ();
    logic [W-1:0] m_data;
    logic         m_valid;
    logic         m_ready;

    modport master (output m_data, output m_valid, input m_ready);
    modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/fir4_avg_fifo.sv
// fir4_avg_fifo: output stage behind the 4-tap moving-sum FIR.
// Rounds the (W+2)-bit sum to a W-bit average ((s+2)>>2), keeps one of
// every decim+1 valid sums, and queues kept averages in a DEPTH-entry FIFO
// presented on a valid/ready stream. Samples arriving at a full FIFO are
// dropped and reported via sticky overflow and a saturating drop counter.
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   i_s_in        : FIR sum, unsigned, W+2 bits
//   i_in_en       : i_s_in valid this cycle
//   i_decim       : keep 1 of every i_decim+1 valid sums
//   i_clr_ovf     : pulse, clears o_overflow and o_drop_cnt
//   m_if          : output stream (m_data / m_valid / m_ready)
//   o_count       : FIFO occupancy 0..DEPTH
//   o_overflow    : sticky drop flag
//   o_drop_cnt    : dropped-sample count, saturates at 255
module fir4_avg_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [W+1:0]               i_s_in,
    input  logic                       i_in_en,
    input  logic [1:0]                 i_decim,
    input  logic                       i_clr_ovf,
    fir4_avg_fifo_if.master            m_if,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_overflow,
    output logic [7:0]                 o_drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [1:0]    r_phase;
    logic [W-1:0]  r_avg;
    logic          r_avg_vld;
    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;
    logic [7:0]    r_drop_cnt;

    logic [W+2:0]  w_sum;
    logic [W-1:0]  w_avg;
    logic          w_keep;
    logic          w_valid;
    logic          w_pop;
    logic          w_full;
    logic          w_push;
    logic          w_drop;

    // One extra bit of headroom so the +2 rounding term cannot carry out;
    // the result after >>2 always fits in W bits for legal FIR sums.
    assign w_sum   = {1'b0, i_s_in} + (W+3)'(2);
    assign w_avg   = W'(w_sum >> 2);
    assign w_keep  = i_in_en && (r_phase == 2'd0);

    assign w_valid = (r_count != '0);
    assign w_pop   = w_valid && m_if.m_ready;
    assign w_full  = (r_count == CW'(DEPTH));
    // A full FIFO still accepts a write when the head leaves this cycle.
    assign w_push  = r_avg_vld && (!w_full || w_pop);
    assign w_drop  = r_avg_vld && w_full && !w_pop;

    assign m_if.m_valid = w_valid;
    assign m_if.m_data  = w_valid ? r_mem[r_rd_ptr] : '0;
    assign o_count      = r_count;
    assign o_overflow   = r_overflow;
    assign o_drop_cnt   = r_drop_cnt;

    // Decimation phase + stage 1 average register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_phase   <= 2'd0;
            r_avg     <= '0;
            r_avg_vld <= 1'b0;
        end else begin
            if (i_in_en)
                r_phase <= (r_phase >= i_decim) ? 2'd0 : r_phase + 2'd1;
            r_avg_vld <= w_keep;
            if (w_keep)
                r_avg <= w_avg;
        end
    end

    // FIFO storage is left uncleared; m_data is masked while empty.
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= r_avg;
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push && !w_pop)
                r_count <= r_count + CW'(1);
            else if (w_pop && !w_push)
                r_count <= r_count - CW'(1);
        end
    end

    // A drop in the same cycle as a clear wins: the clear is applied first,
    // then the drop is counted on top of it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= 8'd0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (i_clr_ovf)
                r_drop_cnt <= 8'd1;
            else if (r_drop_cnt != 8'hFF)
                r_drop_cnt <= r_drop_cnt + 8'd1;
        end else if (i_clr_ovf) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= 8'd0;
        end
    end
endmodule

// File: tb/tb_fir4_avg_fifo.sv
module tb_fir4_avg_fifo;
    localparam int W     = 16;
    localparam int DEPTH = 4;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [W+1:0]       s_in = '0;
    logic               in_en = 1'b0;
    logic [1:0]         decim = 2'd0;
    logic               clr_ovf = 1'b0;
    logic [$clog2(DEPTH):0] count;
    logic               overflow;
    logic [7:0]         drop_cnt;

    fir4_avg_fifo_if #(.W(W)) bus ();

    fir4_avg_fifo #(.W(W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .i_s_in     (s_in),
        .i_in_en    (in_en),
        .i_decim    (decim),
        .i_clr_ovf  (clr_ovf),
        .m_if       (bus),
        .o_count    (count),
        .o_overflow (overflow),
        .o_drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Behavioural model: a queue of averages, a pending kept sample, and
    // a phase number counting valid samples since the last kept one.
    int q[$];
    int pend_vld = 0;
    int pend_val = 0;
    int phase    = 0;
    int m_ovf    = 0;
    int m_drops  = 0;

    function automatic void cmp(string name, int got, int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endfunction

    task automatic model_edge();
        int  sz;
        bit  pop;
        bit  drop;
        if (reset) begin
            q.delete();
            pend_vld = 0;
            phase    = 0;
            m_ovf    = 0;
            m_drops  = 0;
            return;
        end
        sz   = q.size();
        pop  = (sz > 0) && bus.m_ready;
        drop = 0;
        if (pop) void'(q.pop_front());
        if (pend_vld) begin
            if (sz < DEPTH || pop) q.push_back(pend_val);
            else drop = 1;
        end
        if (drop) begin
            m_ovf   = 1;
            m_drops = clr_ovf ? 1 : ((m_drops < 255) ? m_drops + 1 : 255);
        end else if (clr_ovf) begin
            m_ovf   = 0;
            m_drops = 0;
        end
        pend_vld = in_en && (phase == 0);
        pend_val = ((int'(s_in) + 2) / 4) % 65536;
        if (in_en) phase = (phase >= int'(decim)) ? 0 : phase + 1;
    endtask

    task automatic model_check();
        cmp("m_valid",  int'(bus.m_valid), (q.size() > 0) ? 1 : 0);
        cmp("m_data",   int'(bus.m_data),  (q.size() > 0) ? q[0] : 0);
        cmp("count",    int'(count),       q.size());
        cmp("overflow", int'(overflow),    m_ovf);
        cmp("drop_cnt", int'(drop_cnt),    m_drops);
    endtask

    // One clock: inputs were set beforehand; model follows the edge,
    // outputs are compared 1 time unit later.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        model_check();
    endtask

    task automatic do_reset();
        reset = 1'b1; in_en = 1'b0; clr_ovf = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic feed(input int v);
        s_in = (W+2)'(v); in_en = 1'b1;
        step();
    endtask

    initial begin
        bus.m_ready = 1'b1;
        step();
        do_reset();
        cmp("rst_valid", int'(bus.m_valid), 0);
        cmp("rst_data",  int'(bus.m_data), 0);
        cmp("rst_count", int'(count), 0);

        // Full-scale value.
        feed(18'h3FFFC);
        in_en = 1'b0;
        step();
        cmp("fs_valid", int'(bus.m_valid), 1);
        cmp("fs_data",  int'(bus.m_data), 16'hFFFF);

        // Rounding: 1,2,5,6,7 -> 0,1,1,2,2 back-to-back.
        do_reset();
        feed(1);
        feed(2); cmp("rnd0", int'(bus.m_data), 0); cmp("rnd0_v", int'(bus.m_valid), 1);
        feed(5); cmp("rnd1", int'(bus.m_data), 1);
        feed(6); cmp("rnd2", int'(bus.m_data), 1);
        feed(7); cmp("rnd3", int'(bus.m_data), 2);
        in_en = 1'b0;
        step();  cmp("rnd4", int'(bus.m_data), 2);

        // Decimation by 3.
        do_reset();
        decim = 2'd2;
        feed(0);
        feed(4);  cmp("dec0", int'(bus.m_data), 0); cmp("dec0_v", int'(bus.m_valid), 1);
        feed(8);  cmp("dec_gap", int'(bus.m_valid), 0);
        feed(12);
        feed(16); cmp("dec1", int'(bus.m_data), 3);
        feed(20);
        feed(24);
        feed(28); cmp("dec2", int'(bus.m_data), 6);
        decim = 2'd0;

        // Backpressure and overflow.
        do_reset();
        bus.m_ready = 1'b0;
        for (int i = 1; i <= 6; i++) feed(4 * i);
        in_en = 1'b0;
        step();
        cmp("bp_count", int'(count), 4);
        cmp("bp_ovf",   int'(overflow), 1);
        cmp("bp_drops", int'(drop_cnt), 2);
        cmp("bp_head",  int'(bus.m_data), 1);
        bus.m_ready = 1'b1;
        for (int i = 2; i <= 4; i++) begin
            step();
            cmp("bp_drain", int'(bus.m_data), i);
        end
        step();
        cmp("bp_empty", int'(bus.m_valid), 0);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        cmp("clr_ovf", int'(overflow), 0);
        cmp("clr_cnt", int'(drop_cnt), 0);

        // Full FIFO with simultaneous push and pop.
        do_reset();
        bus.m_ready = 1'b0;
        for (int i = 1; i <= 5; i++) feed(4 * i);
        in_en = 1'b0;
        cmp("pp_full", int'(count), 4);
        bus.m_ready = 1'b1;
        step();
        cmp("pp_count", int'(count), 4);
        cmp("pp_ovf",   int'(overflow), 0);
        cmp("pp_head",  int'(bus.m_data), 2);
        bus.m_ready = 1'b0;
        for (int i = 0; i < 305; i++) feed(i * 4);
        cmp("sat_drops", int'(drop_cnt), 255);

        // Reset mid-operation with count=3 and a sample in stage 1.
        do_reset();
        for (int i = 1; i <= 4; i++) feed(40 + 4 * i);
        cmp("mr_count", int'(count), 3);
        do_reset();
        cmp("mr_valid", int'(bus.m_valid), 0);
        cmp("mr_data",  int'(bus.m_data), 0);
        cmp("mr_count0", int'(count), 0);
        cmp("mr_ovf",   int'(overflow), 0);
        bus.m_ready = 1'b1;
        feed(400);
        in_en = 1'b0;
        cmp("mr_lat1", int'(bus.m_valid), 0);
        step();
        cmp("mr_lat2", int'(bus.m_data), 100);

        // Randomized run against the model.
        for (int c = 0; c < 3000; c++) begin
            reset   = ($urandom_range(0, 249) == 0);
            clr_ovf = ($urandom_range(0, 39) == 0);
            in_en   = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 49) == 0) decim = 2'($urandom_range(0, 3));
            bus.m_ready = ($urandom_range(0, 99) < ((c / 500) % 2 == 0 ? 30 : 80));
            case ($urandom_range(0, 9))
                0:       s_in = 18'h3FFFC;
                1:       s_in = 18'h0;
                default: s_in = (W+2)'($urandom_range(0, 18'h3FFFC));
            endcase
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fir4_avg_fifo.md
# fir4_avg_fifo

Output stage placed directly downstream of the 4-tap moving-sum FIR. It takes the FIR's registered (w+2)-bit sum every clock and converts it to a w-bit moving average using round-half-up divide-by-4. It then keeps every (decim+1)-th result and buffers the kept results in a DEPTH-entry FIFO, which it presents to the consumer over a valid/ready handshake. Samples that arrive while the FIFO is full are dropped, and the block reports them through a sticky overflow flag and a saturating drop counter.

## Interface
- w, 16: FIR input sample width; output data width.
- DEPTH, 4: FIFO entries; power of 2, ≥2.
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- s_in  in  w+2  FIR sum, unsigned, new value every clock.
- in_en  in  1  s_in is valid this cycle; normally tied 1.
- decim  in  2  keep 1 of every decim+1 valid sums (1..4).
- clr_ovf  in  1  one-cycle pulse; clears overflow and drop_cnt.
- m_data  out  w  FIFO head average; 0 when m_valid=0.
- m_valid  out  1  FIFO non-empty.
- m_ready  in  1  consumer accepts the head when m_valid&m_ready.
- count  out  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.
- overflow  out  1  sticky: at least one sample dropped.
- drop_cnt  out  8  dropped-sample count; saturates at 255.

## Operation
- Average: avg = (s_in + 2) >> 2, computed at w+3 bits and truncated to w bits. The maximum is (4·(2^w−1)+2)>>2 = 2^w−1, so no saturation logic is needed.
- Decimation phase counter (2 bits), advances only when in_en=1:
  - A sample is kept when phase==0.
  - Next phase = 0 if phase ≥ decim, else phase+1.
  - Lowering decim mid-stream therefore wraps on the next valid sample.
- Stage 1 (avg register): loads avg and sets avg_vld on each valid, kept sample; clears avg_vld otherwise.
- Stage 2 (FIFO write), when avg_vld=1:
  - Write if count<DEPTH, or if count==DEPTH and a pop occurs in the same cycle.
  - Otherwise drop: set overflow, increment drop_cnt (saturating at 255).
- FIFO: circular buffer with wrapping rd/wr pointers.
  - Pop on m_valid&m_ready.
  - Push and pop in the same cycle leave count unchanged.
  - No empty bypass: a write into an empty FIFO is visible the next cycle.
- clr_ovf: clears overflow and drop_cnt. If a drop occurs in the same cycle, the drop wins over the clear: overflow=1, drop_cnt=1.
- Reset, including mid-operation:
  - Flushes the FIFO, avg_vld and phase.
  - Output values after reset: m_valid=0, m_data=0, count=0, overflow=0, drop_cnt=0.
  - FIFO storage contents need not be cleared.
  - Data in flight at reset is discarded and never appears on the output.

## Timing
- Latency: s_in is sampled at edge E (phase 0, FIFO empty) → avg registered at E → written at E+1 → m_valid=1 and m_data valid after E+1. That is 2 cycles.
- Throughput: one kept sample per clock when m_ready=1 and decim=0.
- m_valid and m_data must stay stable until m_valid&m_ready.
- count, overflow and drop_cnt are registered and update on the same edge as the push or pop.
- The drop decision uses the occupancy and pop of the same cycle, never a stale count.

## Test plan
- Full-scale value, w=16, decim=0, m_ready=1:
  - Stimulus: after reset, s_in=18'h3FFFC with in_en=1.
  - Response: m_data=16'hFFFF with m_valid=1, 2 cycles after the sampling edge; count never exceeds 1.
- Rounding, decim=0, m_ready=1:
  - Stimulus: s_in = 1, 2, 5, 6, 7 on consecutive cycles.
  - Response: m_data = 0, 1, 1, 2, 2 on consecutive cycles, with no gaps.
- Decimation, m_ready=1:
  - Stimulus: decim=2, s_in = 0, 4, 8, …, 28 (8 cycles).
  - Response: outputs 0, 3, 6 only, spaced 3 cycles apart.
- Backpressure and overflow, DEPTH=4, decim=0:
  - Stimulus: m_ready=0, s_in = 4, 8, …, 24 (6 samples).
  - Response: count=4, overflow=1, drop_cnt=2, m_data held at 1.
  - Then m_ready=1 → outputs 1, 2, 3, 4 on 4 consecutive cycles, then m_valid=0.
  - Then clr_ovf → overflow=0, drop_cnt=0.
- Full FIFO with simultaneous push and pop:
  - Stimulus: count=4; drive m_ready=1 on the same cycle a kept sample reaches stage 2.
  - Response: count stays 4, no drop, FIFO order preserved.
  - Also: 300 drops → drop_cnt=255.
- Reset mid-operation:
  - Stimulus: assert reset for 1 cycle while count=3 and avg_vld=1.
  - Response: next cycle m_valid=0, m_data=0, count=0, overflow=0; the pre-reset samples never appear; new input resumes with 2-cycle latency.
